cla_seq_addsub: RTL



---
 rtl/cla_seq_addsub_if.sv | 27 ++
 rtl/cla_seq_addsub.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/cla_seq_addsub_if.sv
// Start/done handshake, operand and result/status bundle for cla_seq_addsub.
interface cla_seq_addsub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             c0;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] f;
  logic             c_out;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b, sub, c0,
    input  ready, busy, done, f, c_out, ovf, zero
  );

  modport slave (
    input  start, a, b, sub, c0,
    output ready, busy, done, f, c_out, ovf, zero
  );
endinterface

// File: rtl/cla_seq_addsub.sv
// Multi-cycle add/subtract: one GROUP-bit carry-lookahead slice per clock over a WIDTH-bit operand.
// Optional signed saturation of the result when CLA_SAT_EN is defined.
module cla_seq_addsub #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic            clk,
  input  logic            rst,
  cla_seq_addsub_if.slave bus
);
  localparam int NG  = WIDTH / GROUP;
  localparam int KW  = (NG > 1) ? $clog2(NG) : 1;
  localparam int MSB = WIDTH - 1;
  localparam logic [KW-1:0] K_LAST = KW'(NG - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic             ready_r, busy_r, done_r, c_out_r, ovf_r, zero_r;
  logic [WIDTH-1:0] f_r;

  logic [WIDTH-1:0] a_p0, b_p0, acc_p0;
  logic             carry_p0;

  logic [GROUP-1:0] a_sl, b_sl, sum_sl;
  logic             cout_sl;
  logic [WIDTH-1:0] acc_nxt, f_nxt;
  logic             ovf_nxt;

  // Every carry is a flat sum-of-products of G/P terms and the group carry-in.
  function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] x,
                                               input logic [GROUP-1:0] y,
                                               input logic             cin);
    logic [GROUP-1:0] g, p, s;
    logic [GROUP:0]   c;
    logic             term;
    g    = x & y;
    p    = x | y;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      term = cin;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    s = x ^ y ^ c[GROUP-1:0];
    return {c[GROUP], s};
  endfunction

`ifdef CLA_SAT_EN
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                input logic             ov,
                                                input logic             sign);
    logic signed [WIDTH-1:0] lim;
    if (!ov) return raw;
    lim      = sign ? '0 : '1;
    lim[MSB] = sign;
    return lim;
  endfunction
`endif

  always_comb begin
    a_sl              = a_p0[int'(k)*GROUP +: GROUP];
    b_sl              = b_p0[int'(k)*GROUP +: GROUP];
    {cout_sl, sum_sl} = cla_group(a_sl, b_sl, carry_p0);
    acc_nxt           = acc_p0;
    acc_nxt[int'(k)*GROUP +: GROUP] = sum_sl;
    ovf_nxt           = (a_p0[MSB] == b_p0[MSB]) && (acc_nxt[MSB] != a_p0[MSB]);
`ifdef CLA_SAT_EN
    f_nxt             = saturate(acc_nxt, ovf_nxt, a_p0[MSB]);
`else
    f_nxt             = acc_nxt;
`endif
  end

  // Operand / accumulator datapath: loaded on accept, updated each RUN edge.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      a_p0     <= bus.a;
      b_p0     <= bus.sub ? ~bus.b : bus.b;
      carry_p0 <= bus.c0 ^ bus.sub;
    end else if (state == RUN) begin
      acc_p0   <= acc_nxt;
      carry_p0 <= cout_sl;
    end
  end

  // Control and registered result/status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      f_r     <= '0;
      c_out_r <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state   <= RUN;
            k       <= '0;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        RUN: begin
          if (k == K_LAST) begin
            state   <= DONE;
            done_r  <= 1'b1;
            f_r     <= f_nxt;
            c_out_r <= cout_sl;
            ovf_r   <= ovf_nxt;
            zero_r  <= (f_nxt == '0);
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready = ready_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.f     = f_r;
  assign bus.c_out = c_out_r;
  assign bus.ovf   = ovf_r;
  assign bus.zero  = zero_r;
endmodule
